// File: rtl/receiver_param_if.sv
// receiver_param_if: serial line in, received word and status strobes out.
interface receiver_param_if #(
  parameter int W = 8
);
  logic         din;
  logic         full;
  logic [W-1:0] dout;
  logic         we;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;
  modport master (
    input  din, full,
    output dout, we, parity_err, frame_err, overrun
  );
  modport slave (
    output din, full,
    input  dout, we, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/receiver_param.sv
// receiver_param: parameterised serial receiver; define RECEIVER_MAJORITY_VOTE_EN for 2-of-3 bit voting.
module receiver_param #(
  parameter logic [31:0] CLOCK_FREQUENCY = 32'd100_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115200,
  parameter logic [31:0] WORD_WIDTH      = 32'd8,
  parameter logic [1:0]  PARITY          = 2'd0,
  parameter logic [31:0] STOP_BITS       = 32'd1
) (
  input logic clk,
  input logic rst,
  receiver_param_if.master io_bus
);
  localparam logic [31:0] CPB_RAW   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam logic [31:0] CPB       = (CPB_RAW < 32'd4) ? 32'd4 : CPB_RAW;
  localparam logic [31:0] HALF      = CPB >> 1;
  localparam logic        PAR_EN    = (PARITY == 2'd1) || (PARITY == 2'd2);
  localparam logic        ODD       = PARITY == 2'd1;
  localparam logic [3:0]  LAST_DATA = 4'(WORD_WIDTH - 32'd1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 32'd1);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WRITE, S_BREAK
  } state_t;
  state_t                r_state, w_state_n;
  logic [1:0]            r_sync;
  logic [31:0]           r_cnt, w_cnt_n;
  logic [3:0]            r_bits, w_bits_n;
  logic [WORD_WIDTH-1:0] r_shift, w_shift_n, r_dout;
  logic                  r_par, w_par_n, r_perr, w_perr_n;
  logic                  r_perr_o, r_we, r_fe, r_ov;
  logic                  w_we, w_fe, w_ov;
  logic                  w_din_s, w_bit, w_at_start, w_at_bit;
  assign w_din_s = r_sync[1];
`ifdef RECEIVER_MAJORITY_VOTE_EN
  // Decision moves one count later so the third vote lands after the nominal sample point.
  localparam logic [31:0] OFF = 32'd1;
  logic [1:0] r_hist;
  always_ff @(posedge clk)
    r_hist <= rst ? 2'b11 : {r_hist[0], w_din_s};
  assign w_bit = (w_din_s & r_hist[0]) | (w_din_s & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
  localparam logic [31:0] OFF = 32'd0;
  assign w_bit = w_din_s;
`endif
  assign w_at_start = r_cnt == HALF + OFF;
  assign w_at_bit   = r_cnt == CPB - 32'd1 + OFF;
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt + 32'd1;
    w_bits_n  = r_bits;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_perr_n  = r_perr;
    w_we      = 1'b0;
    w_fe      = 1'b0;
    w_ov      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n   = '0;
        w_state_n = w_din_s ? S_IDLE : S_START;
      end
      S_START: if (w_at_start) begin
        w_cnt_n   = OFF;
        w_bits_n  = '0;
        w_par_n   = 1'b0;
        w_perr_n  = 1'b0;
        w_state_n = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: if (w_at_bit) begin
        w_cnt_n   = OFF;
        w_shift_n = {w_bit, r_shift[WORD_WIDTH-1:1]};
        w_par_n   = r_par ^ w_bit;
        w_bits_n  = (r_bits == LAST_DATA) ? 4'd0 : r_bits + 4'd1;
        w_state_n = (r_bits != LAST_DATA) ? S_DATA : PAR_EN ? S_PARITY : S_STOP;
      end
      S_PARITY: if (w_at_bit) begin
        w_cnt_n   = OFF;
        w_perr_n  = (r_par ^ w_bit) != ODD;
        w_state_n = S_STOP;
      end
      S_STOP: if (w_at_bit) begin
        w_cnt_n   = OFF;
        w_fe      = !w_bit;
        w_bits_n  = r_bits + 4'd1;
        w_state_n = !w_bit ? S_BREAK : (r_bits == LAST_STOP) ? S_WRITE : S_STOP;
      end
      S_WRITE: begin
        w_we      = !io_bus.full;
        w_ov      = io_bus.full;
        w_state_n = S_IDLE;
      end
      S_BREAK: begin
        w_cnt_n   = '0;
        w_state_n = w_din_s ? S_IDLE : S_BREAK;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= 2'b11;
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_perr   <= 1'b0;
      r_dout   <= '0;
      r_perr_o <= 1'b0;
      r_we     <= 1'b0;
      r_fe     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], io_bus.din};
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_bits   <= w_bits_n;
      r_shift  <= w_shift_n;
      r_par    <= w_par_n;
      r_perr   <= w_perr_n;
      r_dout   <= w_we ? r_shift : r_dout;
      r_perr_o <= w_we ? r_perr : r_perr_o;
      r_we     <= w_we;
      r_fe     <= w_fe;
      r_ov     <= w_ov;
    end
  end
  assign io_bus.dout       = r_dout;
  assign io_bus.we         = r_we;
  assign io_bus.parity_err = r_perr_o;
  assign io_bus.frame_err  = r_fe;
  assign io_bus.overrun    = r_ov;
endmodule

// File: tb/tb_receiver_param.sv
// tb_receiver_param: directed and random frames into a no-parity and an even-parity/two-stop receiver.
module tb_receiver_param;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  receiver_param_if #(.W(8)) bn ();
  receiver_param_if #(.W(8)) be ();
  receiver_param #(
    .CLOCK_FREQUENCY(32'd16), .BAUD_RATE(32'd1), .WORD_WIDTH(32'd8), .PARITY(2'd0), .STOP_BITS(32'd1)
  ) u_n (.clk(clk), .rst(rst), .io_bus(bn));
  receiver_param #(
    .CLOCK_FREQUENCY(32'd16), .BAUD_RATE(32'd1), .WORD_WIDTH(32'd8), .PARITY(2'd2), .STOP_BITS(32'd2)
  ) u_e (.clk(clk), .rst(rst), .io_bus(be));
  int n_tests = 0;
  int n_fail  = 0;
  int n_we[2], n_fe[2], n_ov[2];
  int exp_we[2], exp_fe[2], exp_ov[2];
  logic [7:0] exp_dout[2];
  logic       exp_perr[2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      n_we[k] = 0; n_fe[k] = 0; n_ov[k] = 0;
    end
  end
  always @(negedge clk) begin
    if (bn.we) n_we[0]++;
    if (bn.frame_err) n_fe[0]++;
    if (bn.overrun) n_ov[0]++;
    if (be.we) n_we[1]++;
    if (be.frame_err) n_fe[1]++;
    if (be.overrun) n_ov[1]++;
    if (bn.we | bn.frame_err | bn.overrun)
      chk("excl_n", 32'($countones({bn.we, bn.frame_err, bn.overrun})), 32'd1);
    if (be.we | be.frame_err | be.overrun)
      chk("excl_e", 32'($countones({be.we, be.frame_err, be.overrun})), 32'd1);
  end
  task automatic drive_bit(input int which, input logic b, input int cycles);
    if (which == 0) bn.din = b;
    else be.din = b;
    repeat (cycles) @(negedge clk);
  endtask
  task automatic send_frame(input int which, input logic [7:0] d, input logic pb,
                            input logic s0, input logic s1);
    drive_bit(which, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i], CPB);
    if (which == 1) drive_bit(which, pb, CPB);
    drive_bit(which, s0, CPB);
    if (which == 1 && s0) drive_bit(which, s1, CPB);
    if (s0 && (which == 0 || s1)) drive_bit(which, 1'b1, 2 * CPB);
  endtask
  task automatic accept(input int which, input logic [7:0] d, input logic pb);
    exp_we[which]++;
    exp_dout[which] = d;
    exp_perr[which] = (which == 1) ? ((^d) ^ pb) : 1'b0;
  endtask
  task automatic check_dut(input int which, input string tag);
    chk({tag, "_dout"}, 32'(which ? be.dout : bn.dout), 32'(exp_dout[which]));
    chk({tag, "_perr"}, 32'(which ? be.parity_err : bn.parity_err), 32'(exp_perr[which]));
    chk({tag, "_we_cnt"}, 32'(n_we[which]), 32'(exp_we[which]));
    chk({tag, "_fe_cnt"}, 32'(n_fe[which]), 32'(exp_fe[which]));
    chk({tag, "_ov_cnt"}, 32'(n_ov[which]), 32'(exp_ov[which]));
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_n"}, 32'({bn.dout, bn.we, bn.parity_err, bn.frame_err, bn.overrun}), 32'd0);
    chk({tag, "_e"}, 32'({be.dout, be.we, be.parity_err, be.frame_err, be.overrun}), 32'd0);
  endtask
  initial begin
    logic [7:0] d;
    logic       pb;
    for (int k = 0; k < 2; k++) begin
      exp_we[k] = 0; exp_fe[k] = 0; exp_ov[k] = 0; exp_dout[k] = '0; exp_perr[k] = 1'b0;
    end
    rst = 1'b1;
    bn.din = 1'b1; be.din = 1'b1; bn.full = 1'b0; be.full = 1'b0;
    repeat (4) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    accept(0, 8'h5A, 1'b0);
    check_dut(0, "n_5a");
    for (int t = 0; t < 5; t++) begin
      d = 8'($urandom);
      send_frame(0, d, 1'b0, 1'b1, 1'b1);
      accept(0, d, 1'b0);
      check_dut(0, "n_rand");
    end
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1);
    accept(1, 8'h07, 1'b0);
    chk("e_07_pb0_perr", 32'(be.parity_err), 32'd1);
    check_dut(1, "e_07_pb0");
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    accept(1, 8'h07, 1'b1);
    chk("e_07_pb1_perr", 32'(be.parity_err), 32'd0);
    check_dut(1, "e_07_pb1");
    for (int t = 0; t < 5; t++) begin
      d = 8'($urandom);
      pb = 1'($urandom);
      send_frame(1, d, pb, 1'b1, 1'b1);
      accept(1, d, pb);
      check_dut(1, "e_rand");
    end
    send_frame(1, 8'hC3, 1'b0, 1'b1, 1'b0);
    drive_bit(1, 1'b1, 2 * CPB);
    exp_fe[1]++;
    check_dut(1, "e_stop2_low");
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
    drive_bit(0, 1'b0, 50 * CPB);
    chk("n_break_fe_cnt", 32'(n_fe[0]), 32'(exp_fe[0] + 1));
    drive_bit(0, 1'b1, 2 * CPB);
    exp_fe[0]++;
    check_dut(0, "n_break");
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    accept(0, 8'h5A, 1'b0);
    check_dut(0, "n_after_break");
    bn.full = 1'b1;
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    bn.full = 1'b0;
    exp_ov[0]++;
    check_dut(0, "n_overrun");
    bn.din = 1'b0;
    repeat (3) @(negedge clk);
    drive_bit(0, 1'b1, 3 * CPB);
    check_dut(0, "n_glitch");
`ifdef RECEIVER_MAJORITY_VOTE_EN
    drive_bit(0, 1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      drive_bit(0, 1'b1, CPB / 2);
      drive_bit(0, (i == 3) ? 1'b0 : 1'b1, 1);
      drive_bit(0, 1'b1, CPB / 2 - 1);
    end
    drive_bit(0, 1'b1, 3 * CPB);
    accept(0, 8'hFF, 1'b0);
    check_dut(0, "n_vote");
`endif
    d = 8'h3C;
    drive_bit(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i], CPB);
    drive_bit(0, d[4], CPB / 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b0;
    drive_bit(0, 1'b1, 2 * CPB);
    for (int k = 0; k < 2; k++) begin
      exp_dout[k] = '0;
      exp_perr[k] = 1'b0;
    end
    check_dut(0, "n_post_rst");
    check_dut(1, "e_post_rst");
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    accept(0, 8'h3C, 1'b0);
    check_dut(0, "n_3c");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
